// File: rtl/sync_fifo_param_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_param.
// The master modport is the side that drives requests. The slave modport is
// the FIFO itself.
interface sync_fifo_param_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             fifo_flush;
  logic             fifo_write;
  logic [WIDTH-1:0] fifo_data_in;
  logic             fifo_read;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_almost_full;
  logic             fifo_almost_empty;
  logic [CW-1:0]    fifo_count;
  logic             fifo_overflow;
  logic             fifo_underflow;

  modport master (
    output fifo_flush,
    output fifo_write,
    output fifo_data_in,
    output fifo_read,
    input  fifo_data_out,
    input  fifo_full,
    input  fifo_empty,
    input  fifo_almost_full,
    input  fifo_almost_empty,
    input  fifo_count,
    input  fifo_overflow,
    input  fifo_underflow
  );

  modport slave (
    input  fifo_flush,
    input  fifo_write,
    input  fifo_data_in,
    input  fifo_read,
    output fifo_data_out,
    output fifo_full,
    output fifo_empty,
    output fifo_almost_full,
    output fifo_almost_empty,
    output fifo_count,
    output fifo_overflow,
    output fifo_underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO. DEPTH does not have to be a power of two.
// It provides an occupancy count, almost-full/almost-empty thresholds, a
// synchronous flush, and sticky overflow/underflow flags.
// Build option SYNC_FIFO_FWFT_EN selects first-word-fall-through output.
// When that option is absent, read data is registered one cycle after an
// accepted read.
// The interface instance must be built with the same WIDTH/DEPTH as this module.
module sync_fifo_param #(
  parameter int WIDTH         = 16,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_param_if.slave  fifo
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW-1:0] PTR_LAST    = AW'(DEPTH - 1);
  localparam logic [CW-1:0] COUNT_MAX   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LVL   = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_LVL  = CW'(AEMPTY_THRESH);

  // Reject illegal configurations at elaboration rather than misbehave silently.
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_param: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_param: AFULL_THRESH out of range 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_param: AEMPTY_THRESH out of range 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  logic             clear;
  logic             full;
  logic             empty;
  logic             wr_ok;
  logic             rd_ok;

  // Pointers wrap explicitly at DEPTH-1, so any depth works.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Flush has the same effect as reset on all control state.
  assign clear = rst | fifo.fifo_flush;

  // Status is decoded from the registered count, so it is glitch-free and simple.
  assign full  = (count == COUNT_MAX);
  assign empty = (count == '0);

  // Acceptance uses the flags of the current cycle. When full, the read still
  // goes through. When empty, the write still goes through.
  assign wr_ok = fifo.fifo_write & ~full;
  assign rd_ok = fifo.fifo_read  & ~empty;

  // Storage array: not reset, written only on an accepted write outside of a clear.
  always_ff @(posedge clk) begin
    if (!clear && wr_ok) begin
      mem[wr_ptr] <= fifo.fifo_data_in;
    end
  end

  // Pointer, occupancy and sticky error state. A clear wins over same-cycle requests.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (rd_ok) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (fifo.fifo_write && full) begin
        overflow <= 1'b1;
      end
      if (fifo.fifo_read && empty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head-of-queue word is presented directly. It reads as zero while empty.
  assign fifo.fifo_data_out = empty ? '0 : mem[rd_ptr];
`else
  logic [WIDTH-1:0] data_q;

  // Registered read: load the head word on an accepted read, otherwise hold.
  always_ff @(posedge clk) begin
    if (clear) begin
      data_q <= '0;
    end else if (rd_ok) begin
      data_q <= mem[rd_ptr];
    end
  end

  assign fifo.fifo_data_out = data_q;
`endif

  assign fifo.fifo_full         = full;
  assign fifo.fifo_empty        = empty;
  assign fifo.fifo_almost_full  = (count >= AFULL_LVL);
  assign fifo.fifo_almost_empty = (count <= AEMPTY_LVL);
  assign fifo.fifo_count        = count;
  assign fifo.fifo_overflow     = overflow;
  assign fifo.fifo_underflow    = underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param. It drives a DEPTH=16 instance
// against a queue scoreboard, and a DEPTH=5 instance to exercise the
// non-power-of-two pointer wrap.
module tb_sync_fifo_param;

  logic clk;
  logic rst;

  sync_fifo_param_if #(.WIDTH(16), .DEPTH(16)) f16 ();
  sync_fifo_param_if #(.WIDTH(16), .DEPTH(5))  f5 ();

  sync_fifo_param #(
    .WIDTH(16), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .fifo (f16.slave)
  );

  sync_fifo_param #(
    .WIDTH(16), .DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1)
  ) u_dut5 (
    .clk  (clk),
    .rst  (rst),
    .fifo (f5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  logic [15:0] q5[$];
  logic        m_ovf;
  logic        m_udf;
  logic [15:0] m_dout;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_state();
    logic [15:0] exp_d;
    int          sz;
    sz = exp_q.size();
`ifdef SYNC_FIFO_FWFT_EN
    exp_d = (sz == 0) ? 16'h0 : exp_q[0];
`else
    exp_d = m_dout;
`endif
    chk("count",        32'(f16.fifo_count),        32'(sz));
    chk("full",         32'(f16.fifo_full),         32'(sz == 16));
    chk("empty",        32'(f16.fifo_empty),        32'(sz == 0));
    chk("almost_full",  32'(f16.fifo_almost_full),  32'(sz >= 14));
    chk("almost_empty", 32'(f16.fifo_almost_empty), 32'(sz <= 2));
    chk("overflow",     32'(f16.fifo_overflow),     32'(m_ovf));
    chk("underflow",    32'(f16.fifo_underflow),    32'(m_udf));
    chk("data_out",     32'(f16.fifo_data_out),     32'(exp_d));
  endtask

  // One clock of stimulus on the 16-deep FIFO, with the model updated from the
  // requests and the queue state before the edge.
  task automatic step(input logic wr, input logic rd, input logic [15:0] din,
                      input logic fl, input logic rs);
    logic q_full;
    logic q_empty;
    f16.fifo_write   = wr;
    f16.fifo_read    = rd;
    f16.fifo_data_in = din;
    f16.fifo_flush   = fl;
    rst              = rs;
    if (rs || fl) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = 16'h0;
    end else begin
      q_full  = (exp_q.size() == 16);
      q_empty = (exp_q.size() == 0);
      if (wr && q_full)  m_ovf = 1'b1;
      if (rd && q_empty) m_udf = 1'b1;
      if (rd && !q_empty) m_dout = exp_q.pop_front();
      if (wr && !q_full)  exp_q.push_back(din);
    end
    @(posedge clk);
    #1;
    f16.fifo_write = 1'b0;
    f16.fifo_read  = 1'b0;
    f16.fifo_flush = 1'b0;
    rst            = 1'b0;
    check_state();
  endtask

  task automatic step5(input logic wr, input logic rd, input logic [15:0] din);
    f5.fifo_write   = wr;
    f5.fifo_read    = rd;
    f5.fifo_data_in = din;
    @(posedge clk);
    #1;
    f5.fifo_write = 1'b0;
    f5.fifo_read  = 1'b0;
  endtask

  task automatic pop5_check(input logic wr, input logic [15:0] din);
    logic [15:0] exp;
    exp = q5.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
    chk("d5_data", 32'(f5.fifo_data_out), 32'(exp));
    step5(wr, 1'b1, din);
`else
    step5(wr, 1'b1, din);
    chk("d5_data", 32'(f5.fifo_data_out), 32'(exp));
`endif
    if (wr) q5.push_back(din);
    chk("d5_count", 32'(f5.fifo_count), 32'(q5.size()));
  endtask

  initial begin
    f16.fifo_write = 1'b0; f16.fifo_read = 1'b0;
    f16.fifo_flush = 1'b0; f16.fifo_data_in = '0;
    f5.fifo_write  = 1'b0; f5.fifo_read  = 1'b0;
    f5.fifo_flush  = 1'b0; f5.fifo_data_in  = '0;
    rst = 1'b1;
    m_ovf = 1'b0; m_udf = 1'b0; m_dout = 16'h0;

    // Reset state
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

    // Fill with 0x0001..0x0010, then drain in order
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)  step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);

    // Full FIFO with simultaneous write and read
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h2000 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hDEAD, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Empty FIFO: lone read, then read+write together
    step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0055, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);

    // Flush at count 7 with a write pending, then a fresh round trip
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 16'h3000 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h7777, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'hABCD, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h4000 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h4444, 1'b0, 1'b1);

    // Random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom), 1'($urandom_range(0, 39) == 0), 1'b0);
    end

    // DEPTH=5: keep 3 words in flight and stream 12 write/read pairs through the wrap
    chk("d5_empty_rst", 32'(f5.fifo_empty), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step5(1'b1, 1'b0, 16'h0500 + 16'(i));
      q5.push_back(16'h0500 + 16'(i));
    end
    chk("d5_count_fill", 32'(f5.fifo_count), 32'd3);
    for (int i = 3; i < 15; i++) pop5_check(1'b1, 16'h0500 + 16'(i));
    for (int i = 0; i < 3; i++)  pop5_check(1'b0, 16'h0);
    chk("d5_empty",     32'(f5.fifo_empty),     32'd1);
    chk("d5_full",      32'(f5.fifo_full),      32'd0);
    chk("d5_overflow",  32'(f5.fifo_overflow),  32'd0);
    chk("d5_underflow", 32'(f5.fifo_underflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
